mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle main controller for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the write enables and mux/operation selects of the PC, IR, register file, ALU, extender, NPC and data memory. It decodes Op/Funct from the instruction register and samples the ALU Zero flag for branches. It sits between the IR and the datapath inside `mips`.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, valid during BRANCH.
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- RFWr  out  1  register file write enable.
- DMWr  out  1  data memory write enable.
- EXTOp  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16.
- ALUOp  out  2  00 add, 01 sub, 10 or.
- NPCOp  out  2  00 PC+4, 01 branch (PC+4+sext(imm)<<2), 10 jump.
- BSel  out  1  ALU B operand: 0 RD2, 1 extended immediate.
- RegDst  out  1  A3 select: 0 rt, 1 rd.
- WDSel  out  1  WD select: 0 ALU result, 1 DM data.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.
- Illegal  out  1  one-cycle pulse in DECODE for an unsupported Op/Funct.
- State  out  4  current state code (debug).

## Operation
- Supported instructions:
  - R-type: Op 000000 with Funct 100001 addu or 100011 subu.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- States and codes:
  - FETCH 0: IRWr=1, PCWr=1, NPCOp=00 → DECODE.
  - DECODE 1:
    - R-type or ori/lui → EXE.
    - lw/sw → MEMADR.
    - beq → BRANCH.
    - j → JUMP.
    - Anything else → FETCH with Illegal=1.
  - EXE 2: BSel=0 and ALUOp from Funct for R-type; BSel=1 for ori (EXTOp=00, ALUOp=10) and lui (EXTOp=10, ALUOp=10) → ALUWB.
  - ALUWB 7: RFWr=1, WDSel=0, RegDst=1 for R-type, else 0; operand selects held as in EXE; InstrDone=1 → FETCH.
  - MEMADR 3: BSel=1, EXTOp=01, ALUOp=00 → MEMRD for lw, MEMWR for sw.
  - MEMRD 4: address selects held → MEMWB.
  - MEMWB 5: RFWr=1, WDSel=1, RegDst=0, InstrDone=1 → FETCH.
  - MEMWR 6: DMWr=1, address selects held, InstrDone=1 → FETCH.
  - BRANCH 8: BSel=0, ALUOp=01, NPCOp=01, PCWr=Zero, InstrDone=1 → FETCH.
  - JUMP 9: NPCOp=10, PCWr=1, InstrDone=1 → FETCH.
  - Codes 10–15: unreachable; if entered, next state is FETCH with no writes.
- Outputs are decoded from the current state plus Op/Funct. Unlisted selects are 0; unlisted enables are 0.
- Op/Funct are decoded only from DECODE onward; IR is stable after FETCH.
- At most one of RFWr/DMWr is asserted in any cycle. PCWr is never asserted outside FETCH, BRANCH and JUMP.

## Timing
- Reset: State=FETCH (0). All outputs are 0 while rst is high; PCWr and IRWr are suppressed during reset.
- First FETCH occurs in the first cycle after rst deasserts.
- Cycles per instruction, FETCH to last state inclusive:
  - R-type, ori, lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, j: 3.
  - Illegal: 2.
- The state register updates on the rising edge. Outputs are combinational from the registered state and the IR fields, with no added latency.
- Zero is sampled combinationally in BRANCH; its value at the end of that cycle decides PCWr.
- Reset asserted mid-instruction: state returns to FETCH immediately, asynchronously. No partial write completes after rst rises.

## Test plan
- Reset sequence: hold rst 3 cycles, release → State=0, then PCWr=IRWr=1 in the first cycle, State=1 in the next.
- addu (Op=0, Funct=0x21): states 0,1,2,7. In the ALUWB cycle RFWr=1, RegDst=1, WDSel=0, ALUOp=00, InstrDone=1.
- lw (Op=0x23): states 0,1,3,4,5.
  - MEMADR: BSel=1, EXTOp=01.
  - MEMWB: RFWr=1, WDSel=1, RegDst=0.
- sw (Op=0x2B): states 0,1,3,6. DMWr=1 only in state 6; RFWr stays 0 throughout.
- beq: with Zero=1, PCWr=1 and NPCOp=01 in state 8; with Zero=0, PCWr=0. j: state 9 gives PCWr=1, NPCOp=10.
- Illegal Op=0x3F: Illegal pulses in state 1, then state 0 with no RFWr/DMWr. Also assert rst while in state 4 → State=0 asynchronously, and no RFWr pulse occurs.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: IR fields and Zero into the controller, datapath controls out.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       PCWr;
   logic       IRWr;
   logic       RFWr;
   logic       DMWr;
   logic [1:0] EXTOp;
   logic [1:0] ALUOp;
   logic [1:0] NPCOp;
   logic       BSel;
   logic       RegDst;
   logic       WDSel;
   logic       InstrDone;
   logic       Illegal;
   logic [3:0] State;

   modport master (
      input  Op, Funct, Zero,
      output PCWr, IRWr, RFWr, DMWr,
      output EXTOp, ALUOp, NPCOp,
      output BSel, RegDst, WDSel,
      output InstrDone, Illegal, State
   );

   modport slave (
      output Op, Funct, Zero,
      input  PCWr, IRWr, RFWr, DMWr,
      input  EXTOp, ALUOp, NPCOp,
      input  BSel, RegDst, WDSel,
      input  InstrDone, Illegal, State
   );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller (fetch/decode/exe/mem/wb).
// Ports: clk, rst (async, active-high), bus (mc_ctrl_if.master).
module mc_ctrl (
   input  logic        clk,
   input  logic        rst,
   mc_ctrl_if.master   bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXE    = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9
   } state_e;

   state_e state_q, state_d;

   logic is_addu, is_subu, is_rtype;
   logic is_ori, is_lui, is_lw, is_sw;
   logic is_beq, is_j, legal;

   assign is_addu  = (bus.Op == 6'h00) &&
                     (bus.Funct == 6'h21);
   assign is_subu  = (bus.Op == 6'h00) &&
                     (bus.Funct == 6'h23);
   assign is_rtype = is_addu | is_subu;
   assign is_ori   = (bus.Op == 6'h0D);
   assign is_lui   = (bus.Op == 6'h0F);
   assign is_lw    = (bus.Op == 6'h23);
   assign is_sw    = (bus.Op == 6'h2B);
   assign is_beq   = (bus.Op == 6'h04);
   assign is_j     = (bus.Op == 6'h02);
   assign legal    = is_rtype | is_ori | is_lui |
                     is_lw | is_sw | is_beq | is_j;

   // ALU operand selects shared by EXE and ALUWB
   logic       ex_bsel;
   logic [1:0] ex_ext;
   logic [1:0] ex_alu;

   always_comb begin
      ex_bsel = 1'b0;
      ex_ext  = 2'b00;
      ex_alu  = 2'b00;
      if (is_ori) begin
         ex_bsel = 1'b1;
         ex_alu  = 2'b10;
      end else if (is_lui) begin
         ex_bsel = 1'b1;
         ex_ext  = 2'b10;
         ex_alu  = 2'b10;
      end else if (is_subu) begin
         ex_alu  = 2'b01;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   logic       pc_wr, ir_wr, rf_wr, dm_wr;
   logic [1:0] ext_op, alu_op, npc_op;
   logic       b_sel, reg_dst, wd_sel;
   logic       done, ill;

   always_comb begin
      state_d = S_FETCH;
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      rf_wr   = 1'b0;
      dm_wr   = 1'b0;
      ext_op  = 2'b00;
      alu_op  = 2'b00;
      npc_op  = 2'b00;
      b_sel   = 1'b0;
      reg_dst = 1'b0;
      wd_sel  = 1'b0;
      done    = 1'b0;
      ill     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            unique case (1'b1)
               is_rtype | is_ori | is_lui:
                  state_d = S_EXE;
               is_lw | is_sw:
                  state_d = S_MEMADR;
               is_beq:
                  state_d = S_BRANCH;
               is_j:
                  state_d = S_JUMP;
               default: begin
                  state_d = S_FETCH;
                  ill     = 1'b1;
               end
            endcase
         end
         S_EXE: begin
            b_sel   = ex_bsel;
            ext_op  = ex_ext;
            alu_op  = ex_alu;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            b_sel   = ex_bsel;
            ext_op  = ex_ext;
            alu_op  = ex_alu;
            rf_wr   = 1'b1;
            reg_dst = is_rtype;
            done    = 1'b1;
         end
         S_MEMADR: begin
            b_sel   = 1'b1;
            ext_op  = 2'b01;
            state_d = is_sw ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            b_sel   = 1'b1;
            ext_op  = 2'b01;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rf_wr   = 1'b1;
            wd_sel  = 1'b1;
            done    = 1'b1;
         end
         S_MEMWR: begin
            b_sel   = 1'b1;
            ext_op  = 2'b01;
            dm_wr   = 1'b1;
            done    = 1'b1;
         end
         S_BRANCH: begin
            alu_op  = 2'b01;
            npc_op  = 2'b01;
            pc_wr   = bus.Zero;
            done    = 1'b1;
         end
         S_JUMP: begin
            npc_op  = 2'b10;
            pc_wr   = 1'b1;
            done    = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      // state_q is already FETCH under reset; mask
      // FETCH's writes so nothing fires while rst is high
      if (rst) begin
         pc_wr   = 1'b0;
         ir_wr   = 1'b0;
         rf_wr   = 1'b0;
         dm_wr   = 1'b0;
         ext_op  = 2'b00;
         alu_op  = 2'b00;
         npc_op  = 2'b00;
         b_sel   = 1'b0;
         reg_dst = 1'b0;
         wd_sel  = 1'b0;
         done    = 1'b0;
         ill     = 1'b0;
      end
   end

   assign bus.PCWr      = pc_wr;
   assign bus.IRWr      = ir_wr;
   assign bus.RFWr      = rf_wr;
   assign bus.DMWr      = dm_wr;
   assign bus.EXTOp     = ext_op;
   assign bus.ALUOp     = alu_op;
   assign bus.NPCOp     = npc_op;
   assign bus.BSel      = b_sel;
   assign bus.RegDst    = reg_dst;
   assign bus.WDSel     = wd_sel;
   assign bus.InstrDone = done;
   assign bus.Illegal   = ill;
   assign bus.State     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream against a per-instruction
// step table of expected controls; compared every cycle.
module tb_mc_ctrl;

   typedef struct packed {
      logic       pcwr;
      logic       irwr;
      logic       rfwr;
      logic       dmwr;
      logic [1:0] ext;
      logic [1:0] alu;
      logic [1:0] npc;
      logic       bsel;
      logic       regdst;
      logic       wdsel;
      logic       done;
      logic       ill;
      logic [3:0] st;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mc_ctrl_if bus ();

   mc_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   vec_t act;
   assign act = {bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr,
                 bus.EXTOp, bus.ALUOp, bus.NPCOp,
                 bus.BSel, bus.RegDst, bus.WDSel,
                 bus.InstrDone, bus.Illegal, bus.State};

   int   n_pass = 0;
   int   n_tot  = 0;
   vec_t exp_v  = '0;
   bit   chk_en = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] a,
                      input logic [31:0] e);
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, a, e);
   endtask

   // classes: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw
   //          6 beq 7 j 8 illegal
   function automatic int ilen(int c);
      case (c)
         4:       return 5;
         6, 7:    return 3;
         8:       return 2;
         default: return 4;
      endcase
   endfunction

   // Expected controls for step s (0 = FETCH) of class c
   function automatic vec_t model(int c, int s, logic z);
      vec_t v = '0;
      if (s == 0) begin
         v.pcwr = 1; v.irwr = 1; v.st = 0;
         return v;
      end
      if (s == 1) begin
         v.st = 1; v.ill = (c == 8);
         return v;
      end
      case (c)
         0, 1, 2, 3: begin
            v.st   = (s == 2) ? 4'd2 : 4'd7;
            v.bsel = (c >= 2);
            v.ext  = (c == 3) ? 2'd2 : 2'd0;
            v.alu  = (c == 1) ? 2'd1 : (c >= 2) ? 2'd2 : 2'd0;
            if (s == 3) begin
               v.rfwr = 1; v.regdst = (c < 2); v.done = 1;
            end
         end
         4: begin
            if (s == 4) begin
               v.st = 5; v.rfwr = 1; v.wdsel = 1; v.done = 1;
            end else begin
               v.st = (s == 2) ? 4'd3 : 4'd4;
               v.bsel = 1; v.ext = 2'd1;
            end
         end
         5: begin
            v.st = (s == 2) ? 4'd3 : 4'd6;
            v.bsel = 1; v.ext = 2'd1;
            if (s == 3) begin
               v.dmwr = 1; v.done = 1;
            end
         end
         6: begin
            v.st = 8; v.alu = 2'd1; v.npc = 2'd1;
            v.pcwr = z; v.done = 1;
         end
         7: begin
            v.st = 9; v.npc = 2'd2; v.pcwr = 1; v.done = 1;
         end
         default: ;
      endcase
      return v;
   endfunction

   function automatic bit is_legal(logic [5:0] op,
                                   logic [5:0] fn);
      if (op == 6'h00) return (fn == 6'h21 || fn == 6'h23);
      return op inside {6'h0D, 6'h0F, 6'h23, 6'h2B,
                        6'h04, 6'h02};
   endfunction

   task automatic gen(input int c,
                      output logic [5:0] op,
                      output logic [5:0] fn);
      fn = 6'($urandom);
      case (c)
         0: begin op = 6'h00; fn = 6'h21; end
         1: begin op = 6'h00; fn = 6'h23; end
         2: op = 6'h0D;
         3: op = 6'h0F;
         4: op = 6'h23;
         5: op = 6'h2B;
         6: op = 6'h04;
         7: op = 6'h02;
         default: begin
            do begin
               op = ($urandom_range(0, 3) == 0) ? 6'h00
                    : 6'($urandom);
               fn = 6'($urandom);
            end while (is_legal(op, fn));
         end
      endcase
   endtask

   // zm: 0/1 fixed Zero, 2 random each cycle
   task automatic run(input int c, input logic [5:0] op,
                      input logic [5:0] fn, input int zm);
      for (int s = 0; s < ilen(c); s++) begin
         bus.Op    = op;
         bus.Funct = fn;
         bus.Zero  = (zm == 2) ? 1'($urandom) : zm[0];
         exp_v     = model(c, s, bus.Zero);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_rand(input int c);
      logic [5:0] op, fn;
      gen(c, op, fn);
      run(c, op, fn, 2);
   endtask

   always @(negedge clk) begin
      if (chk_en) chk("cyc", 32'(act), 32'(exp_v));
   end

   initial begin
      vec_t v;
      logic [5:0] op, fn;

      v = model(0, 3, 0);
      chk("pin_addu_wb",
          {v.rfwr, v.regdst, v.wdsel, v.alu, v.done, v.st},
          {1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 4'd7});
      v = model(4, 2, 0);
      chk("pin_lw_madr", {v.bsel, v.ext, v.st},
          {1'b1, 2'b01, 4'd3});
      v = model(4, 4, 0);
      chk("pin_lw_wb", {v.rfwr, v.wdsel, v.regdst, v.st},
          {1'b1, 1'b1, 1'b0, 4'd5});
      v = model(5, 3, 0);
      chk("pin_sw_wr", {v.dmwr, v.rfwr, v.st},
          {1'b1, 1'b0, 4'd6});
      v = model(6, 2, 1);
      chk("pin_beq_z1", {v.pcwr, v.npc, v.st},
          {1'b1, 2'b01, 4'd8});
      v = model(6, 2, 0);
      chk("pin_beq_z0", {31'd0, v.pcwr}, 32'd0);
      v = model(7, 2, 0);
      chk("pin_j", {v.pcwr, v.npc, v.st},
          {1'b1, 2'b10, 4'd9});
      v = model(8, 1, 0);
      chk("pin_ill", {v.ill, v.st}, {1'b1, 4'd1});

      bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;
      exp_v  = '0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      run(0, 6'h00, 6'h21, 0);
      run(1, 6'h00, 6'h23, 0);
      run(2, 6'h0D, 6'h15, 0);
      run(3, 6'h0F, 6'h3A, 0);
      run(4, 6'h23, 6'h00, 0);
      run(5, 6'h2B, 6'h00, 0);
      run(6, 6'h04, 6'h00, 1);
      run(6, 6'h04, 6'h00, 0);
      run(7, 6'h02, 6'h00, 0);
      run(8, 6'h3F, 6'h00, 0);
      run(8, 6'h00, 6'h20, 0);

      // lw interrupted by reset while in MEMRD
      for (int s = 0; s < 4; s++) begin
         bus.Op = 6'h23; bus.Funct = 6'h00;
         exp_v  = model(4, s, 1'b0);
         if (s < 3) begin
            @(posedge clk);
            #1;
         end
      end
      @(negedge clk);
      #1;
      rst   = 1'b1;
      exp_v = '0;
      #1;
      chk("async_rst_state", 32'(bus.State), 32'd0);
      chk("async_rst_rfwr", 32'(bus.RFWr), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      run(0, 6'h00, 6'h21, 0);

      for (int i = 0; i < 400; i++) begin
         run_rand($urandom_range(0, 8));
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
